// File: rtl/io_port_pkg.sv
`default_nettype none
// ============================================================================
// io_port_pkg : shared defaults and write-source encodings for io_port_bank
// Rev 1.0
// ============================================================================
package io_port_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_NPORTS = 4;

  typedef enum logic {
    SEL_WD0 = 1'b0,
    SEL_WD1 = 1'b1
  } wr_sel_e;

endpackage : io_port_pkg
`default_nettype wire

// File: rtl/io_in_chan.sv
`default_nettype none
// ============================================================================
// io_in_chan : one input channel (optional sync + edge detect, capture
//              register, full and sticky overrun flags). Macro: IO_PORT_SYNC_EN
// Rev 1.0
// ============================================================================
module io_in_chan
  import io_port_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             overrun_o
);

  logic             cap;
  logic [WIDTH-1:0] din;

`ifdef IO_PORT_SYNC_EN
  logic [1:0]       strb_sync_q;
  logic             strb_prev_q;
  logic [WIDTH-1:0] data_s1_q;
  logic [WIDTH-1:0] data_s2_q;

  // Data rides alongside the strobe so it is aligned when the edge is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      strb_sync_q <= '0;
      strb_prev_q <= 1'b0;
      data_s1_q   <= '0;
      data_s2_q   <= '0;
    end else begin
      strb_sync_q <= {strb_sync_q[0], strobe_i};
      strb_prev_q <= strb_sync_q[1];
      data_s1_q   <= data_i;
      data_s2_q   <= data_s1_q;
    end
  end

  assign cap = strb_sync_q[1] & ~strb_prev_q;
  assign din = data_s2_q;
`else
  assign cap = strobe_i;
  assign din = data_i;
`endif

  logic [WIDTH-1:0] data_q, data_d;
  logic             full_q, full_d;
  logic             ovr_q,  ovr_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    ovr_d  = ovr_q;
    if (cap) begin
      data_d = din;
      full_d = 1'b1;
      if (full_q && !rd_i) begin
        ovr_d = 1'b1;
      end
    end else if (rd_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      ovr_q  <= ovr_d;
    end
  end

  assign data_o    = data_q;
  assign full_o    = full_q;
  assign overrun_o = ovr_q;

endmodule : io_in_chan
`default_nettype wire

// File: rtl/io_port_bank.sv
`default_nettype none
// ============================================================================
// io_port_bank : NPORTS registered output ports plus NPORTS captured input
//                channels sharing one address. Macro: IO_PORT_SYNC_EN
// Rev 1.0
// ============================================================================
module io_port_bank
  import io_port_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NPORTS = DEFAULT_NPORTS,
  parameter int AW     = $clog2(NPORTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           addr,
  input  logic                    wr_en,
  input  logic                    wr_sel,
  input  logic [WIDTH-1:0]        wd0,
  input  logic [WIDTH-1:0]        wd1,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  input  logic [NPORTS*WIDTH-1:0] in_ports,
  input  logic [NPORTS-1:0]       in_strobe,
  output logic [NPORTS*WIDTH-1:0] out_ports,
  output logic [NPORTS-1:0]       out_strobe,
  output logic [NPORTS-1:0]       overrun
);

  // ---------------------------------------------------------------- write path
  logic [WIDTH-1:0]  out_q [NPORTS];
  logic [WIDTH-1:0]  out_d [NPORTS];
  logic [NPORTS-1:0] ostb_q, ostb_d;
  logic [WIDTH-1:0]  wdata;

  assign wdata = (wr_sel_e'(wr_sel) == SEL_WD1) ? wd1 : wd0;

  always_comb begin
    ostb_d = '0;
    for (int i = 0; i < NPORTS; i++) begin
      out_d[i] = out_q[i];
    end
    if (wr_en) begin
      out_d[addr]  = wdata;
      ostb_d[addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ostb_q <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        out_q[i] <= '0;
      end
    end else begin
      ostb_q <= ostb_d;
      for (int i = 0; i < NPORTS; i++) begin
        out_q[i] <= out_d[i];
      end
    end
  end

  assign out_strobe = ostb_q;

  // ----------------------------------------------------------------- read path
  logic [WIDTH-1:0]  chan_data [NPORTS];
  logic [NPORTS-1:0] chan_full;

  generate
    for (genvar g = 0; g < NPORTS; g++) begin : g_port
      logic rd_hit;
      assign rd_hit = rd_en && (addr == AW'(g));
      assign out_ports[g*WIDTH +: WIDTH] = out_q[g];

      io_in_chan #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk       (clk),
        .reset     (reset),
        .strobe_i  (in_strobe[g]),
        .data_i    (in_ports[g*WIDTH +: WIDTH]),
        .rd_i      (rd_hit),
        .data_o    (chan_data[g]),
        .full_o    (chan_full[g]),
        .overrun_o (overrun[g])
      );
    end
  endgenerate

  assign rd_data  = chan_data[addr];
  assign rd_valid = chan_full[addr];

endmodule : io_port_bank
`default_nettype wire

// File: doc/io_port_bank.md
IO_PORT_BANK -- requirements
Module: io_port_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of every port; SHALL be 1..32.
REQ-002 Parameter NPORTS, default 4, number of input ports and of output ports; SHALL be a power of two, 2..16; derived AW = log2(NPORTS).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 addr  in  AW  port select for both write and read.
REQ-007 wr_en  in  1  output-port write strobe.
REQ-008 wr_sel  in  1  write source: 0 = wd0, 1 = wd1.
REQ-009 wd0, wd1  in  WIDTH each  candidate write data.
REQ-010 rd_en  in  1  read acknowledge; consumes the selected input port.
REQ-011 rd_data  out  WIDTH  captured data of input port addr.
REQ-012 rd_valid  out  1  input port addr holds unread data.
REQ-013 in_ports  in  NPORTS*WIDTH  external input data; port i = bits [i*WIDTH +: WIDTH].
REQ-014 in_strobe  in  NPORTS  per-port "new data present" from the external device.
REQ-015 out_ports  out  NPORTS*WIDTH  registered output ports, same slicing.
REQ-016 out_strobe  out  NPORTS  one-cycle pulse marking an output-port update.
REQ-017 overrun  out  NPORTS  sticky per-port data-lost flag.

Function
REQ-018 Write: at an edge with wr_en=1, out_ports[addr] SHALL load (wr_sel ? wd1 : wd0); all other output ports hold.
REQ-019 out_strobe[addr] SHALL be 1 for exactly the cycle after the write edge; 0 otherwise; back-to-back writes give back-to-back pulses.
REQ-020 Capture: at an edge with the effective strobe of port i high, in_reg[i] SHALL load in_ports slice i and full[i] SHALL become 1.
REQ-021 rd_data SHALL be in_reg[addr] combinationally; rd_valid SHALL be full[addr] combinationally.
REQ-022 At an edge with rd_en=1, full[addr] SHALL clear; rd_en with full[addr]=0 SHALL be harmless (no state change).
REQ-023 Capture when full[i]=1 and port i not read at that edge: data overwritten with newest, overrun[i] SHALL set and stay set until reset.
REQ-024 Simultaneous capture and rd_en on same port: new data loaded, full stays 1, overrun unchanged.
REQ-025 Write and read paths SHALL be independent; wr_en and rd_en in the same cycle on any addr both take effect.
REQ-026 Latency: output port visible 1 cycle after wr_en; captured data visible on rd_data immediately after the capture edge.

Reset
REQ-027 At an edge with reset=1: out_ports, out_strobe, all in_reg, full, overrun and synchroniser flops SHALL be 0.
REQ-028 reset SHALL override wr_en, rd_en and in_strobe at the same edge; a reset mid-transaction discards it.

Configuration
REQ-029 Macro IO_PORT_SYNC_EN defined: in_strobe and in_ports pass two-flop synchronisers; capture on the rising edge of the synchronised strobe only (one capture per strobe assertion); strobe-to-rd_valid latency 3 cycles.
REQ-030 Macro IO_PORT_SYNC_EN undefined: in_strobe is a synchronous level; every cycle it is high captures; strobe-to-rd_valid latency 1 cycle.

Structure
REQ-031 Package io_port_pkg SHALL hold default WIDTH/NPORTS constants and wr_sel encodings SEL_WD0=0, SEL_WD1=1.
REQ-032 Sub-module io_in_chan SHALL implement one input channel (sync, edge detect, in_reg, full, overrun), generated NPORTS times.

Verification
REQ-033 Reset, then wr_en addr=2 wr_sel=1 wd1=0xA5 -> next cycle out_ports port2=0xA5, out_strobe=4'b0100 one cycle, other ports 0.
REQ-034 in_strobe[1] one cycle with port1=0x3C (no macro) -> next cycle addr=1 gives rd_data=0x3C, rd_valid=1; rd_en -> rd_valid=0.
REQ-035 Two strobes on port 0 (0x11, 0x22) without read -> rd_data=0x22, overrun[0]=1, persists after rd_en until reset.
REQ-036 rd_en addr=3 and in_strobe[3] same edge with full[3]=1, data 0x7E -> rd_data=0x7E, rd_valid=1, overrun[3]=0.
REQ-037 wr_en addr=0 wd0=0xFF with reset=1 same edge -> out_ports port0=0x00, out_strobe=0.
REQ-038 IO_PORT_SYNC_EN, in_strobe[2] held high 5 cycles -> exactly one capture, rd_valid rises 3 cycles after assertion.
